// File: rtl/clk_div_multi_pkg.sv
// clk_div_pkg: shared constants and types for the clk_div_multi divider slice.
//   CNT_W_DEF   default width of period/high/counter fields
//   RST_PERIOD  period field loaded at reset (period = RST_PERIOD+1 cycles)
//   RST_HIGH    high-time loaded at reset
//   ch_idx_w()  width of a channel index, never less than 1
//   ch_state_e  per-channel run state (tracks "disabled last cycle")
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned RST_PERIOD = 1;
  localparam int unsigned RST_HIGH   = 1;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: configuration bus of the multi-channel divider.
//   cfg_we      config write strobe, one cycle
//   cfg_ch      target channel of the write (out-of-range index is ignored)
//   cfg_period  period length minus 1
//   cfg_high    number of high cycles per period
//   cfg_pend    per-channel flag: shadow written but not yet active
// master drives the write fields and observes cfg_pend; slave is the divider.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  localparam int unsigned CW = ch_idx_w(NUM_CH);

  logic              cfg_we;
  logic [CW-1:0]     cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] cfg_pend;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_high,
    input  cfg_pend
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_high,
    output cfg_pend
  );

endinterface

// File: rtl/clk_div_multi_ch.sv
// clk_div_ch: one divider channel.
//   clk, rst_n  system clock, asynchronous active-low reset
//   en          run enable, level-sensitive
//   we          shadow write strobe for this channel
//   period/high new shadow values {P, H}
//   sync        forced period start (tie low when unused)
//   pend        shadow written but not yet loaded into the active set
//   clk_out     divided waveform, registered
//   tick        one-cycle pulse at each period start, registered
// Shadow {P,H} is copied to the active set only at a period start, so the
// counter can never run past P_act and the waveform never glitches.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  input  logic             sync,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] p_sh;
  logic [CNT_W-1:0] h_sh;
  logic [CNT_W-1:0] p_act;
  logic [CNT_W-1:0] h_act;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] h_new;
  logic             ps;
  ch_state_e        state;

  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    // Period start: enable edge, natural wrap, or external realign.
    ps      = en && ((state == CH_IDLE) || (cnt == p_act) || sync);
    // High-time that will be active after this edge's period start.
    h_new   = pend ? h_sh : h_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CH_IDLE;
      p_sh    <= CNT_W'(RST_PERIOD);
      h_sh    <= CNT_W'(RST_HIGH);
      p_act   <= CNT_W'(RST_PERIOD);
      h_act   <= CNT_W'(RST_HIGH);
      pend    <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state <= en ? CH_RUN : CH_IDLE;

      if (we) begin
        p_sh <= period;
        h_sh <= high;
      end

      // A write on a period-start edge re-arms pend for the next period;
      // the load below still uses the pre-write shadow.
      if (we) begin
        pend <= 1'b1;
      end else if (ps) begin
        pend <= 1'b0;
      end

      if (ps) begin
        if (pend) begin
          p_act <= p_sh;
          h_act <= h_sh;
        end
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (h_new != '0);
      end else if (en) begin
        cnt     <= cnt_inc;
        tick    <= 1'b0;
        clk_out <= (cnt_inc < h_act);
      end else begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock-enable/divider generator.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ch_en     per-channel run enable
//   cfg       configuration bus (clk_div_multi_if.slave)
//   clk_out   per-channel divided waveform, registered
//   tick      per-channel period-start pulse, registered
//   sync_in   global phase realign, present only with CLK_DIV_SYNC_EN
// Optional feature macro: CLK_DIV_SYNC_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_en,
  clk_div_multi_if.slave      cfg,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                sync_in
`endif
);

  localparam int unsigned CW = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] ch_we;
  logic [NUM_CH-1:0] pend;
  logic              sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Indices at or above NUM_CH match no channel, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = cfg.cfg_we && (cfg.cfg_ch == CW'(i));

    clk_div_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ch_en[i]),
      .we     (ch_we[i]),
      .period (cfg.cfg_period),
      .high   (cfg.cfg_high),
      .sync   (sync),
      .pend   (pend[i]),
      .clk_out(clk_out[i]),
      .tick   (tick[i])
    );
  end

  assign cfg.cfg_pend = pend;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: self-checking bench for clk_div_multi (NUM_CH=3).
// A behavioural channel model predicts {cfg_pend, tick, clk_out} for every
// clock edge; predictions are queued at the edge and compared #1 later.
// Builds with or without CLK_DIV_SYNC_EN.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned VW     = 3 * NUM_CH;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLK_DIV_SYNC_EN
  logic              sync_in = 1'b0;
`endif

  clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg ();

  clk_div_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ch_en  (ch_en),
    .cfg    (cfg.slave),
    .clk_out(clk_out),
    .tick   (tick)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync_in(sync_in)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [VW-1:0] sb[$];

  int unsigned m_psh [NUM_CH];
  int unsigned m_hsh [NUM_CH];
  int unsigned m_pact[NUM_CH];
  int unsigned m_hact[NUM_CH];
  int unsigned m_cnt [NUM_CH];
  bit          m_pend[NUM_CH];
  bit          m_run [NUM_CH];
  bit          m_out [NUM_CH];
  bit          m_tick[NUM_CH];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_psh[c] = 1; m_hsh[c] = 1; m_pact[c] = 1; m_hact[c] = 1;
      m_cnt[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_out[c] = 0; m_tick[c] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    bit sy;
`ifdef CLK_DIV_SYNC_EN
    sy = sync_in;
`else
    sy = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      bit en;
      bit we;
      bit ps;
      en = ch_en[c];
      we = cfg.cfg_we && (int'(cfg.cfg_ch) == c);
      ps = en && (!m_run[c] || (m_cnt[c] == m_pact[c]) || sy);
      if (ps) begin
        if (m_pend[c]) begin
          m_pact[c] = m_psh[c];
          m_hact[c] = m_hsh[c];
          m_pend[c] = 0;
        end
        m_cnt[c]  = 0;
        m_tick[c] = 1;
        m_out[c]  = (m_hact[c] != 0);
      end else if (en) begin
        m_cnt[c]  = m_cnt[c] + 1;
        m_tick[c] = 0;
        m_out[c]  = (m_cnt[c] < m_hact[c]);
      end else begin
        m_cnt[c]  = 0;
        m_tick[c] = 0;
        m_out[c]  = 0;
      end
      if (we) begin
        m_psh[c]  = int'(cfg.cfg_period);
        m_hsh[c]  = int'(cfg.cfg_high);
        m_pend[c] = 1;
      end
      m_run[c] = en;
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [NUM_CH-1:0] p, t, o;
    for (int c = 0; c < NUM_CH; c++) begin
      p[c] = m_pend[c];
      t[c] = m_tick[c];
      o[c] = m_out[c];
    end
    return {p, t, o};
  endfunction

  task automatic step(input int unsigned n);
    logic [VW-1:0] exp;
    repeat (n) begin
      @(posedge clk);
      model_step();
      sb.push_back(model_vec());
      #1;
      exp = sb.pop_front();
      check("cycle", 32'({cfg.cfg_pend, tick, clk_out}), 32'(exp));
    end
  endtask

  task automatic cfg_write(input int unsigned ch, input int unsigned p, input int unsigned h);
    cfg.cfg_we     = 1'b1;
    cfg.cfg_ch     = 2'(ch);
    cfg.cfg_period = CNT_W'(p);
    cfg.cfg_high   = CNT_W'(h);
    step(1);
    cfg.cfg_we     = 1'b0;
  endtask

  task automatic count(input int unsigned ch, input int unsigned n,
                       output int unsigned hi, output int unsigned tk);
    hi = 0;
    tk = 0;
    repeat (n) begin
      step(1);
      hi += int'(clk_out[ch]);
      tk += int'(tick[ch]);
    end
  endtask

  task automatic wait_tick(input int unsigned ch, input int unsigned limit);
    bit found;
    found = 0;
    for (int unsigned i = 0; i < limit; i++) begin
      step(1);
      if (tick[ch]) begin
        found = 1;
        break;
      end
    end
    check("tick_timeout", 32'(found), 32'(1));
  endtask

  initial begin
    int unsigned hi;
    int unsigned tk;
    int unsigned guard;

    cfg.cfg_we     = 1'b0;
    cfg.cfg_ch     = '0;
    cfg.cfg_period = '0;
    cfg.cfg_high   = '0;
    model_reset();

    #12;
    check("reset", 32'({cfg.cfg_pend, tick, clk_out}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Default divide-by-2 on ch0.
    ch_en[0] = 1'b1;
    step(1);
    check("ch0_first_out", 32'(clk_out[0]), 32'(1));
    count(0, 8, hi, tk);
    check("ch0_hi", hi, 4);
    check("ch0_tk", tk, 4);
    ch_en[0] = 1'b0;
    step(1);

    // 30 % duty on ch1.
    cfg_write(1, 9, 3);
    check("ch1_pend_set", 32'(cfg.cfg_pend[1]), 32'(1));
    ch_en[1] = 1'b1;
    count(1, 20, hi, tk);
    check("ch1_hi", hi, 6);
    check("ch1_tk", tk, 2);
    check("ch1_pend_clr", 32'(cfg.cfg_pend[1]), 32'(0));

    // Mid-period reconfiguration on ch2.
    cfg_write(2, 3, 2);
    ch_en[2] = 1'b1;
    step(5);
    cfg_write(2, 7, 4);
    check("ch2_pend_wait", 32'(cfg.cfg_pend[2]), 32'(1));
    wait_tick(2, 8);
    check("ch2_pend_clr", 32'(cfg.cfg_pend[2]), 32'(0));
    count(2, 8, hi, tk);
    check("ch2_new_hi", hi, 4);
    check("ch2_new_tk", tk, 1);
    ch_en = '0;
    step(1);

    // Boundary high-times and zero period.
    cfg_write(0, 4, 0);
    ch_en[0] = 1'b1;
    count(0, 10, hi, tk);
    check("h0_hi", hi, 0);
    check("h0_tk", tk, 2);
    cfg_write(1, 9, 20);
    ch_en[1] = 1'b1;
    count(1, 20, hi, tk);
    check("hbig_hi", hi, 20);
    check("hbig_tk", tk, 2);
    cfg_write(2, 0, 1);
    ch_en[2] = 1'b1;
    count(2, 5, hi, tk);
    check("p0_tk", tk, 5);
    ch_en = '0;
    step(1);

    // Out-of-range channel index.
    cfg_write(3, 5, 5);
    check("bad_ch_pend", 32'(cfg.cfg_pend), 32'(0));
    ch_en[0] = 1'b1;
    count(0, 5, hi, tk);
    check("bad_ch_hi", hi, 0);
    ch_en = '0;
    step(1);

    // Write landing exactly on the wrap edge.
    cfg_write(2, 3, 2);
    ch_en[2] = 1'b1;
    step(2);
    cfg_write(2, 5, 1);
    guard = 0;
    while (!(m_cnt[2] == m_pact[2]) && guard < 20) begin
      step(1);
      guard++;
    end
    check("wrap_align", 32'(guard < 20), 32'(1));
    cfg_write(2, 2, 1);
    check("wrap_first_tick", 32'(tick[2]), 32'(1));
    check("wrap_second_pend", 32'(cfg.cfg_pend[2]), 32'(1));
    count(2, 6, hi, tk);
    check("wrap_hi", hi, 1);
    check("wrap_tk", tk, 1);
    check("wrap_pend_clr", 32'(cfg.cfg_pend[2]), 32'(0));

    // Asynchronous reset mid-period with a pending write.
    ch_en[1] = 1'b1;
    cfg_write(1, 7, 7);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({cfg.cfg_pend, tick, clk_out}), 32'(0));
    model_reset();
    ch_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ch_en[0] = 1'b1;
    count(0, 6, hi, tk);
    check("post_rst_hi", hi, 3);
    check("post_rst_tk", tk, 3);
    ch_en = '0;
    step(1);

`ifdef CLK_DIV_SYNC_EN
    // Realign two out-of-phase channels.
    cfg_write(0, 4, 2);
    cfg_write(1, 6, 3);
    ch_en[0] = 1'b1;
    step(2);
    ch_en[1] = 1'b1;
    step(3);
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
    check("sync_tick", 32'(tick[1:0]), 32'(2'b11));
    step(14);
    ch_en = '0;
    step(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
